// File: rtl/ppi_ctrl_if.sv
// CPU bus, peripheral handshake and slice-control bundle for the PPI control unit.
// The master side is the CPU/peripheral environment; the slave side is ppi_ctrl.
interface ppi_ctrl_if #(
  parameter int ADDR_W = 2
);
  logic              cs;
  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        din;
  logic              stb_a;
  logic              ack_a;
  logic              a_mode;
  logic              a_en;
  logic              b_mode;
  logic              b_en;
  logic              a_capture;
  logic [7:0]        pc_out;
  logic [7:0]        pc_oe;
  logic              intr_a;
  logic              ovr_a;

  modport master (
    output cs, rd, wr, addr, din, stb_a, ack_a,
    input  a_mode, a_en, b_mode, b_en, a_capture, pc_out, pc_oe, intr_a, ovr_a
  );

  modport slave (
    input  cs, rd, wr, addr, din, stb_a, ack_a,
    output a_mode, a_en, b_mode, b_en, a_capture, pc_out, pc_oe, intr_a, ovr_a
  );
endinterface

// File: rtl/ppi_ctrl.sv
// 8255-style PPI control unit: bus decode, control word / BSR handling,
// port C output latch and the port A mode-1 strobed handshake.
module ppi_ctrl #(
  parameter logic [7:0] CW_RESET = 8'h9B,
  parameter int         ADDR_W   = 2
) (
  input logic       clk,
  input logic       reset,
  ppi_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    STROBED,
    FULL,
    READING,
    WRITING,
    OBF,
    ACKED
  } hs_state_t;

  hs_state_t         state;
  logic [7:0]        cw;
  logic [7:0]        pc_latch;
  logic [7:0]        din_s;
  logic [ADDR_W-1:0] addr_s;
  logic              cs_s;
  logic              rd_s, rd_p, wr_s, wr_p;
  logic              stb_s, stb_p, ack_s, ack_p;
  logic              ibf, obf, intr, inte, ovr, cap;

  // Bus qualifiers travel with the strobes so an edge is judged against the
  // chip select and address that were present when it happened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_s   <= 1'b0;
      addr_s <= '0;
      din_s  <= 8'h00;
      rd_s   <= 1'b0;
      rd_p   <= 1'b0;
      wr_s   <= 1'b0;
      wr_p   <= 1'b0;
      stb_s  <= 1'b0;
      stb_p  <= 1'b0;
      ack_s  <= 1'b0;
      ack_p  <= 1'b0;
    end else begin
      cs_s   <= bus.cs;
      addr_s <= bus.addr;
      din_s  <= bus.din;
      rd_s   <= bus.rd;
      rd_p   <= rd_s;
      wr_s   <= bus.wr;
      wr_p   <= wr_s;
      stb_s  <= bus.stb_a;
      stb_p  <= stb_s;
      ack_s  <= bus.ack_a;
      ack_p  <= ack_s;
    end
  end

  logic       rd_rise, rd_fall, wr_rise, wr_fall;
  logic       stb_rise, stb_fall, ack_rise, ack_fall;
  logic       sel_a, sel_ctl, mode1, a_in;
  logic       cw_set, bsr, bsr_inte;
  logic [2:0] bsr_bit;

  assign rd_rise  = cs_s & rd_s & ~rd_p;
  assign rd_fall  = cs_s & ~rd_s & rd_p;
  assign wr_rise  = cs_s & wr_s & ~wr_p;
  assign wr_fall  = cs_s & ~wr_s & wr_p;
  assign stb_rise = stb_s & ~stb_p;
  assign stb_fall = ~stb_s & stb_p;
  assign ack_rise = ack_s & ~ack_p;
  assign ack_fall = ~ack_s & ack_p;

  assign sel_a    = (addr_s == '0);
  assign sel_ctl  = (addr_s == {ADDR_W{1'b1}});
  assign mode1    = (cw[6:5] == 2'b01);
  assign a_in     = cw[4];
  assign cw_set   = wr_rise & sel_ctl & din_s[7] & ~din_s[6];
  assign bsr      = wr_rise & sel_ctl & ~din_s[7];
  assign bsr_bit  = din_s[3:1];
  // In mode 1 the handshake input pin (PC4 or PC6) doubles as the INTE flag.
  assign bsr_inte = mode1 & (a_in ? (bsr_bit == 3'd4) : (bsr_bit == 3'd6));

  // A control write overrides everything, including a handshake in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cw       <= CW_RESET;
      pc_latch <= 8'h00;
      state    <= IDLE;
      ibf      <= 1'b0;
      obf      <= 1'b0;
      intr     <= 1'b0;
      inte     <= 1'b0;
      ovr      <= 1'b0;
      cap      <= 1'b0;
    end else begin
      cap <= 1'b0;
      if (cw_set) begin
        cw       <= din_s;
        pc_latch <= 8'h00;
        state    <= IDLE;
        ibf      <= 1'b0;
        obf      <= 1'b0;
        intr     <= 1'b0;
        inte     <= 1'b0;
        ovr      <= 1'b0;
      end else begin
        if (bsr) begin
          if (bsr_inte) inte <= din_s[0];
          else          pc_latch[bsr_bit] <= din_s[0];
        end
        if (!mode1) begin
          state <= IDLE;
          intr  <= 1'b0;
        end else begin
          case (state)
            IDLE: begin
              if (a_in && stb_rise) begin
                cap   <= 1'b1;
                ibf   <= 1'b1;
                state <= STROBED;
              end else if (!a_in && wr_rise && sel_a) begin
                intr  <= 1'b0;
                state <= WRITING;
              end
            end
            STROBED: begin
              if (stb_fall) begin
                intr  <= inte;
                state <= FULL;
              end
            end
            FULL: begin
              if (stb_rise) ovr <= 1'b1;
              if (rd_rise && sel_a) begin
                intr  <= 1'b0;
                state <= READING;
              end
            end
            READING: begin
              if (rd_fall && sel_a) begin
                ibf   <= 1'b0;
                state <= IDLE;
              end
            end
            WRITING: begin
              if (wr_fall && sel_a) begin
                obf   <= 1'b1;
                state <= OBF;
              end
            end
            OBF: begin
              if (ack_rise) begin
                obf   <= 1'b0;
                state <= ACKED;
              end else if (wr_rise && sel_a) begin
                state <= WRITING;
              end
            end
            ACKED: begin
              if (ack_fall) begin
                intr  <= inte;
                state <= IDLE;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.a_mode    = cw[4];
  assign bus.b_mode    = cw[1];
  assign bus.a_en      = bus.cs & (bus.addr == '0) & (cw[4] ? bus.rd : bus.wr);
  assign bus.b_en      = bus.cs & (bus.addr == ADDR_W'(1)) & (cw[1] ? bus.rd : bus.wr);
  assign bus.a_capture = cap;
  assign bus.intr_a    = intr;
  assign bus.ovr_a     = ovr;

  // Handshake bits replace latch bits in mode 1; everything else stays mode-0.
  always_comb begin
    bus.pc_out = pc_latch;
    bus.pc_oe  = {{4{~cw[3]}}, {4{~cw[0]}}};
    if (mode1) begin
      bus.pc_out[3] = intr;
      bus.pc_oe[3]  = 1'b1;
      if (a_in) begin
        bus.pc_out[5] = ibf;
        bus.pc_oe[5]  = 1'b1;
        bus.pc_oe[4]  = 1'b0;
      end else begin
        bus.pc_out[7] = obf;
        bus.pc_oe[7]  = 1'b1;
        bus.pc_oe[6]  = 1'b0;
      end
    end
  end

endmodule
